// File: rtl/hbuf_rdout_streamer.sv
// Drains one header-buffer DPRAM record into a 16-bit valid/ready stream, answering the dpram_run/busy/done handshake.
// Optional trailing 16-bit checksum word when HBUF_RDOUT_CKSUM_EN is defined.
module hbuf_rdout_streamer #(
  parameter int P_ADR_WIDTH = 9,
  parameter int P_LEN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dpram_run,
  input  logic [P_LEN_WIDTH-1:0] dpram_len,
  output logic                   dpram_busy,
  output logic                   dpram_done,
  output logic [P_ADR_WIDTH-1:0] rd_addr,
  input  logic [63:0]            rd_data,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   len_err
);

  localparam int CAP_W = P_ADR_WIDTH + 3;
  localparam int REM_W = (P_LEN_WIDTH > CAP_W) ? P_LEN_WIDTH : CAP_W;
  localparam logic [REM_W-1:0] CAP = REM_W'(4) << P_ADR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_CKSUM, S_DONE
  } state_t;

  state_t           state_q;
  logic [REM_W-1:0] rem_q;
  logic [63:0]      lane_q;
  logic [1:0]       lane_idx_q;
  logic [P_ADR_WIDTH-1:0] rd_addr_q;
  logic [15:0]      out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             len_err_q;
`ifdef HBUF_RDOUT_CKSUM_EN
  logic [15:0]      sum_q;
`endif

  logic [REM_W-1:0] len_ext_d;
  logic             len_sat_d;
  logic [REM_W-1:0] rem_start_d;

  assign len_ext_d   = REM_W'(dpram_len);
  assign len_sat_d   = (len_ext_d > CAP);
  assign rem_start_d = len_sat_d ? CAP : len_ext_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      lane_q      <= '0;
      lane_idx_q  <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
`ifdef HBUF_RDOUT_CKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (dpram_run) begin
            rem_q      <= rem_start_d;
            rd_addr_q  <= '0;
            lane_idx_q <= '0;
            busy_q     <= 1'b1;
            if (len_sat_d) len_err_q <= 1'b1;
`ifdef HBUF_RDOUT_CKSUM_EN
            sum_q      <= '0;
`endif
            state_q    <= (rem_start_d == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          lane_q      <= rd_data;
          out_data_q  <= rd_data[15:0];
          lane_idx_q  <= '0;
          rd_addr_q   <= rd_addr_q + 1'b1;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            // Lane register shifts down so the next lane is always in [31:16].
            rem_q      <= rem_q - 1'b1;
            lane_idx_q <= lane_idx_q + 1'b1;
            lane_q     <= lane_q >> 16;
            out_data_q <= lane_q[31:16];
`ifdef HBUF_RDOUT_CKSUM_EN
            sum_q      <= sum_q + out_data_q;
`endif
            if (rem_q == REM_W'(1)) begin
`ifdef HBUF_RDOUT_CKSUM_EN
              out_data_q <= sum_q + out_data_q;
              state_q    <= S_CKSUM;
`else
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
`endif
            end else if (lane_idx_q == 2'd3) begin
              out_valid_q <= 1'b0;
              state_q     <= S_FETCH;
            end
          end
        end
`ifdef HBUF_RDOUT_CKSUM_EN
        S_CKSUM: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // A zero-length record arrives here with done still low and pulses one cycle later.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign dpram_busy = busy_q;
  assign dpram_done = done_q;
  assign rd_addr    = rd_addr_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_hbuf_rdout_streamer.sv
// Bench for hbuf_rdout_streamer: directed and random records checked against a queue-based stream model.
module tb_hbuf_rdout_streamer;
  localparam int AW  = 9;
  localparam int LW  = 16;
  localparam int CAP = 4 * (1 << AW);

  logic          clk = 1'b0;
  logic          rst;
  logic          dpram_run;
  logic [LW-1:0] dpram_len;
  logic          dpram_busy;
  logic          dpram_done;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          len_err;

  logic [63:0] mem [0:(1<<AW)-1];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic err_exp = 1'b0;

  hbuf_rdout_streamer #(.P_ADR_WIDTH(AW), .P_LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .dpram_run(dpram_run), .dpram_len(dpram_len),
    .dpram_busy(dpram_busy), .dpram_done(dpram_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream: first min(len,CAP) 16-bit lanes of DPRAM in address order, plus sum if enabled.
  task automatic build_exp(input int len);
    int n;
    logic [63:0] w;
    logic [15:0] s;
    n = (len > CAP) ? CAP : len;
    s = '0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w = mem[i / 4];
      exp_q.push_back(w[16*(i%4) +: 16]);
      s = s + w[16*(i%4) +: 16];
    end
`ifdef HBUF_RDOUT_CKSUM_EN
    if (n > 0) exp_q.push_back(s);
`endif
  endtask

  // rmode: 0 ready always high, 1 alternate 1-0-1, 2 random
  task automatic run_record(input string tag, input int len, input int rmode, input bit inject);
    int t, n, first_v, done_c, done_cnt, exp_done;
    bit pv, pr;
    logic [15:0] pd;
    n = (len > CAP) ? CAP : len;
    build_exp(len);
    if (len > CAP) err_exp = 1'b1;
    got_q.delete();
    first_v = -1; done_c = -1; done_cnt = 0; pv = 0; pr = 0; pd = '0;
    chk({tag, "_idle_busy"}, dpram_busy, 0);
    out_ready = 1'b1;
    dpram_run = 1'b1;
    dpram_len = LW'(len);
    t = cyc;
    while (1) begin
      step();
      dpram_run = 1'b0;
      if (inject && cyc == t + 10) begin
        dpram_run = 1'b1;
        dpram_len = LW'(4);
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2) == 0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == t + 1) chk({tag, "_busy_rise"}, dpram_busy, 1);
      if (pv && !pr) begin
        chk({tag, "_stall_valid"}, out_valid, 1);
        chk({tag, "_stall_data"}, out_data, pd);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (dpram_done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = cyc;
          chk({tag, "_busy_at_done"}, dpram_busy, 1);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (done_c >= 0 && cyc == done_c + 1) begin
        chk({tag, "_busy_fall"}, dpram_busy, 0);
        break;
      end
      if (cyc > t + 20000) begin
        chk({tag, "_timeout"}, 1, 0);
        break;
      end
    end
    out_ready = 1'b1;
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    chk({tag, "_first_valid"}, first_v, (n > 0) ? t + 3 : -1);
    if (rmode == 0) begin
      exp_done = (n == 0) ? t + 2 : t + 1 + n + 2 * ((n + 3) / 4);
`ifdef HBUF_RDOUT_CKSUM_EN
      if (n > 0) exp_done = exp_done + 1;
`endif
      chk({tag, "_done_cycle"}, done_c, exp_done);
    end
    chk({tag, "_len_err"}, len_err, err_exp);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    dpram_run = 1'b0;
    dpram_len = '0;
    out_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    step(); step();
    chk("rst_busy", dpram_busy, 0);
    chk("rst_done", dpram_done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    step();

    run_record("len8", 8, 0, 0);
    run_record("len5", 5, 0, 0);
    run_record("len0", 0, 0, 0);
    run_record("toggle", 8, 1, 0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      run_record("rand", $urandom_range(1, 40), 2, 0);
    end
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    run_record("sat", 3000, 0, 1);

    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    dpram_len = LW'(8);
    dpram_run = 1'b1;
    step();
    dpram_run = 1'b0;
    for (int k = 0; k < 50 && !(out_valid && out_data == 16'd3); k++) step();
    chk("mid_word3", out_data, 16'd3);
    #2 rst = 1'b1;
    #1;
    err_exp = 1'b0;
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", dpram_busy, 0);
    chk("mid_addr", rd_addr, 0);
    chk("mid_len_err", len_err, 0);
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dpram_done) done_seen++;
    end
    chk("mid_no_done", done_seen, 0);
    run_record("after_rst", 8, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hbuf_rdout_streamer.md
# hbuf_rdout_streamer

Drains one waveform record from the header-buffer readout DPRAM and streams it as 16-bit words over a valid/ready interface. It sits directly downstream of `wvb_reader`. It answers the `dpram_run` / `dpram_busy` / `dpram_done` handshake, so `wvb_reader` can refill the DPRAM as soon as each record has been consumed. It replaces the behavioural DPRAM drain loop used in the buffer integration benches with synthesizable logic.

## Interface

Parameters:
- `P_ADR_WIDTH`, default 9: DPRAM read-address width, in 64-bit words.
- `P_LEN_WIDTH`, default 16: width of `dpram_len`, in 16-bit words.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: asynchronous, active-high reset.
- `dpram_run`, in, 1: one-cycle pulse from `wvb_reader`; a record is ready.
- `dpram_len`, in, `P_LEN_WIDTH`: record length in 16-bit words. Valid in the cycle `dpram_run` is high.
- `dpram_busy`, out, 1: high while a record is being drained.
- `dpram_done`, out, 1: one-cycle pulse when the record is fully drained.
- `rd_addr`, out, `P_ADR_WIDTH`: DPRAM port-B read address.
- `rd_data`, in, 64: DPRAM port-B data, one-cycle registered latency.
- `out_data`, out, 16: stream word.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the word.
- `len_err`, out, 1: sticky; set when a record length exceeded DPRAM capacity. Cleared by reset only.

## Operation

- States: IDLE, FETCH, LOAD, SEND, CKSUM, DONE.
- **IDLE**
  - When `dpram_run` = 1:
    - Latch `rem` = `dpram_len`, saturated to 4·2^`P_ADR_WIDTH`. Set `len_err` if saturation occurred.
    - Set `rd_addr` = 0.
  - If the latched length is 0, go to DONE. Otherwise go to FETCH.
  - `dpram_run` outside IDLE is ignored.
- **FETCH**: `rd_addr` is stable for one cycle, covering the read latency; go to LOAD.
- **LOAD**
  - Capture `rd_data` into a 64-bit lane register and set lane = 0.
  - Increment `rd_addr`, wrapping modulo 2^`P_ADR_WIDTH`; the wrap only occurs at maximum length.
  - Go to SEND.
- **SEND**
  - `out_data` = lane register bits [16·lane+15 : 16·lane], so lane 0 = bits [15:0]. `out_valid` = 1.
  - On each `out_valid` & `out_ready`:
    - Decrement `rem` and increment lane.
    - If `rem` reaches 0: go to CKSUM if the feature is compiled in, else to DONE. A final partial 64-bit word emits only the lanes still needed; unused lanes are discarded.
    - Else, if lane 3 was just accepted, go to FETCH.
- **DONE**: pulse `dpram_done` for one cycle and go to IDLE.
- `dpram_busy` = 1 in every state except IDLE.
- `out_data` holds its value while `out_valid` = 1 and `out_ready` = 0, per standard valid/ready rules. `out_valid` never drops without a handshake.
- Reset mid-record: the block returns immediately to IDLE. All outputs clear, no `dpram_done` is issued, and the partial record is lost.

## Timing

- Reset values: `dpram_busy`, `dpram_done`, `out_valid`, `len_err` = 0; `rd_addr` = 0; `out_data` = 0.
- `dpram_run` in cycle T:
  - `dpram_busy` = 1 from T+1.
  - The first `out_valid` appears at T+3 (IDLE→FETCH→LOAD→SEND).
- Each group of 4 words costs 4 handshake cycles plus 2 (FETCH, LOAD). With `out_ready` tied high, N words take N + 2·⌈N/4⌉ cycles from first FETCH to the last accept.
- `dpram_done` is asserted in the cycle after the last accepted word (after the checksum word when `HBUF_RDOUT_CKSUM_EN` is defined). `dpram_busy` falls in the cycle after `dpram_done`.
- Zero-length record: `dpram_done` at T+2, and no `out_valid` is ever asserted.
- `dpram_busy` never rises in the same cycle as `dpram_run`. The earliest next run accepted is the cycle after `dpram_busy` falls.

## Configuration

- `HBUF_RDOUT_CKSUM_EN` defined:
  - A 16-bit running sum is kept, modulo 2^16 over all emitted data words. It is cleared when a record is accepted in IDLE.
  - After the last data word, CKSUM presents the sum as one extra stream word with `out_valid` = 1, then goes to DONE on handshake.
  - The stream length is `dpram_len` + 1, or 0 for a zero-length record.
- Undefined: no CKSUM state, no adder, and the stream length equals `dpram_len`.

## Test plan

- DPRAM word 0 = 0x0004_0003_0002_0001, word 1 = 0x0008_0007_0006_0005, `dpram_len` = 8, `out_ready` = 1 → stream 1,2,…,8, then `dpram_done` one cycle later. With the checksum feature, the stream is followed by 0x0024.
- `dpram_len` = 5, same data → words 1,2,3,4,5 only; lanes 6–8 are discarded; `dpram_busy` returns to 0.
- `dpram_len` = 0 → no `out_valid`; `dpram_busy` high for exactly 2 cycles; `dpram_done` at T+2.
- `out_ready` toggled 1-0-1 with record 1–8 → `out_data` stable while stalled; every word delivered exactly once, in order.
- `dpram_len` = 3000 with `P_ADR_WIDTH` = 9 → `len_err` = 1 and exactly 2048 words are streamed. A second `dpram_run` pulsed while busy is ignored.
- `rst` asserted during SEND of word 3 → `out_valid`, `dpram_busy`, `rd_addr` = 0 asynchronously and no `dpram_done`. A following run streams the full record correctly.
